// File: rtl/tile_lane_engine_if.sv
// Signal bundle between the tile lane engine and its key/draw/score neighbours.
// master = engine side, slave = input/display side.
interface tile_lane_engine_if #(
    parameter int LANES = 4,
    parameter int ROWS  = 7
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                startn;
    logic [LANES-1:0]    key_press;
    logic [ROWS*LW-1:0]  row_lane;
    logic [ROWS-1:0]     row_valid;
    logic [15:0]         score;
    logic                hit_pulse;
    logic                miss_pulse;
    logic                shift_pulse;
    logic [1:0]          lives_left;
    logic                game_over;
    logic [1:0]          state;

    modport master (
        input  startn, key_press,
        output row_lane, row_valid, score, hit_pulse, miss_pulse, shift_pulse,
               lives_left, game_over, state
    );

    modport slave (
        output startn, key_press,
        input  row_lane, row_valid, score, hit_pulse, miss_pulse, shift_pulse,
               lives_left, game_over, state
    );
endinterface

// File: rtl/tile_lane_engine.sv
// Piano-tiles game core: falling-tile rows, self-timed scroll with speed-up, hit checking and score.
// Define TILE_ENGINE_LIVES_EN to give the player three lives instead of ending on the first miss.
module tile_lane_engine #(
    parameter int          LANES         = 4,
    parameter int          ROWS          = 7,
    parameter int          TICK_INIT     = 25000000,
    parameter int          TICK_MIN      = 5000000,
    parameter int          SPEEDUP_EVERY = 8,
    parameter int          SPEEDUP_STEP  = 1000000,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic               clock,
    input  logic               resetn,
    tile_lane_engine_if.master bus
);
    localparam int          LW       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
`ifdef TILE_ENGINE_LIVES_EN
    localparam logic [1:0]  LIVES_START = 2'd3;
`else
    localparam logic [1:0]  LIVES_START = 2'd0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ROWS*LW-1:0]  row_lane_reg, row_lane_next;
    logic [ROWS-1:0]     row_valid_reg, row_valid_next;
    logic [15:0]         score_reg, score_next;
    logic                hit_reg, hit_next;
    logic                miss_reg, miss_next;
    logic                shift_reg, shift_next;
    logic [1:0]          lives_reg, lives_next;
    logic [31:0]         period_reg, period_next;
    logic [31:0]         cnt_reg, cnt_next;
    logic [15:0]         hit_cnt_reg, hit_cnt_next;
    logic [15:0]         lfsr_reg, lfsr_next;

    logic [LW-1:0]       lane_raw;
    logic [LW-1:0]       lane_new;
    logic [LANES-1:0]    lane_onehot;
    logic [ROWS-1:0]     valid_shifted;
    logic [ROWS*LW-1:0]  lane_shifted;
    logic                tick;
    logic                hit;
    logic                miss_ev;
    logic                do_shift;

    assign lane_raw      = lfsr_reg[LW-1:0];
    assign lane_new      = ({{(32-LW){1'b0}}, lane_raw} >= 32'(LANES)) ? lane_raw - LW'(LANES) : lane_raw;
    assign lane_onehot   = {{(LANES-1){1'b0}}, 1'b1} << row_lane_reg[LW-1:0];
    assign valid_shifted = {1'b1, row_valid_reg[ROWS-1:1]};
    assign lane_shifted  = {lane_new, row_lane_reg[ROWS*LW-1:LW]};

    always_comb begin
        state_next     = state_reg;
        row_lane_next  = row_lane_reg;
        row_valid_next = row_valid_reg;
        score_next     = score_reg;
        hit_next       = 1'b0;
        miss_next      = 1'b0;
        shift_next     = 1'b0;
        lives_next     = lives_reg;
        period_next    = period_reg;
        cnt_next       = cnt_reg;
        hit_cnt_next   = hit_cnt_reg;
        lfsr_next      = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        tick           = 1'b0;
        hit            = 1'b0;
        miss_ev        = 1'b0;
        do_shift       = 1'b0;

        case (state_reg)
            ST_RUN: begin
                // >= rather than == so a speed-up that drops the period below the running count still ticks
                tick     = (cnt_reg >= period_reg - 32'd1);
                cnt_next = tick ? 32'd0 : cnt_reg + 32'd1;

                if (|bus.key_press) begin
                    if (row_valid_reg[0] && (bus.key_press == lane_onehot)) begin
                        hit               = 1'b1;
                        hit_next          = 1'b1;
                        row_valid_next[0] = 1'b0;
                        if (score_reg != 16'hFFFF)
                            score_next = score_reg + 16'd1;
                        if (hit_cnt_reg == 16'(SPEEDUP_EVERY - 1)) begin
                            hit_cnt_next = 16'd0;
                            period_next  = (period_reg >= 32'(TICK_MIN + SPEEDUP_STEP)) ?
                                           period_reg - 32'(SPEEDUP_STEP) : 32'(TICK_MIN);
                        end else begin
                            hit_cnt_next = hit_cnt_reg + 16'd1;
                        end
                    end else begin
                        miss_ev = 1'b1;
                    end
                end

                // A tile still sitting in the hit row when the scroll fires was never played
                if (tick && row_valid_reg[0] && !hit)
                    miss_ev = 1'b1;

                if (miss_ev) begin
                    miss_next = 1'b1;
`ifdef TILE_ENGINE_LIVES_EN
                    lives_next = lives_reg - 2'd1;
                    if (lives_reg == 2'd1)
                        state_next = ST_OVER;
                    else if (tick)
                        do_shift = 1'b1;
`else
                    state_next = ST_OVER;
`endif
                end else if (tick) begin
                    do_shift = 1'b1;
                end

                if (do_shift) begin
                    row_valid_next = valid_shifted;
                    row_lane_next  = lane_shifted;
                    shift_next     = 1'b1;
                end
            end

            default: begin
                // IDLE and OVER keep the last board on display until a start request
                if (!bus.startn) begin
                    state_next     = ST_RUN;
                    row_lane_next  = '0;
                    row_valid_next = '0;
                    score_next     = 16'd0;
                    period_next    = 32'(TICK_INIT);
                    cnt_next       = 32'd0;
                    hit_cnt_next   = 16'd0;
                    lives_next     = LIVES_START;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            row_lane_reg  <= '0;
            row_valid_reg <= '0;
            score_reg     <= 16'd0;
            hit_reg       <= 1'b0;
            miss_reg      <= 1'b0;
            shift_reg     <= 1'b0;
            lives_reg     <= LIVES_START;
            period_reg    <= 32'(TICK_INIT);
            cnt_reg       <= 32'd0;
            hit_cnt_reg   <= 16'd0;
            lfsr_reg      <= SEED_EFF;
        end else begin
            state_reg     <= state_next;
            row_lane_reg  <= row_lane_next;
            row_valid_reg <= row_valid_next;
            score_reg     <= score_next;
            hit_reg       <= hit_next;
            miss_reg      <= miss_next;
            shift_reg     <= shift_next;
            lives_reg     <= lives_next;
            period_reg    <= period_next;
            cnt_reg       <= cnt_next;
            hit_cnt_reg   <= hit_cnt_next;
            lfsr_reg      <= lfsr_next;
        end
    end

    assign bus.row_lane    = row_lane_reg;
    assign bus.row_valid   = row_valid_reg;
    assign bus.score       = score_reg;
    assign bus.hit_pulse   = hit_reg;
    assign bus.miss_pulse  = miss_reg;
    assign bus.shift_pulse = shift_reg;
    assign bus.lives_left  = lives_reg;
    assign bus.game_over   = (state_reg == ST_OVER);
    assign bus.state       = state_reg;
endmodule

// File: tb/tb_tile_lane_engine.sv
// Directed bench for tile_lane_engine with shrunk timing; tick spacing expectations go through a scoreboard queue.
module tb_tile_lane_engine;
    localparam int LANES = 4;
    localparam int ROWS  = 7;
    localparam int LW    = 2;
`ifdef TILE_ENGINE_LIVES_EN
    localparam logic [1:0] LIVES_EXP = 2'd3;
`else
    localparam logic [1:0] LIVES_EXP = 2'd0;
`endif

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    tile_lane_engine_if #(.LANES(LANES), .ROWS(ROWS)) bus ();

    tile_lane_engine #(
        .LANES(LANES), .ROWS(ROWS), .TICK_INIT(20), .TICK_MIN(8),
        .SPEEDUP_EVERY(2), .SPEEDUP_STEP(4), .SEED(16'hACE1)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference LFSR; lfsr_used is the value the DUT saw at the most recent edge
    logic [15:0] lfsr_m, lfsr_used;
    always @(posedge clock) begin
        lfsr_used <= lfsr_m;
        if (!resetn) lfsr_m <= 16'hACE1;
        else         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    logic [LW-1:0]   m_lane [ROWS];
    logic [ROWS-1:0] m_valid;
    int              exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [ROWS*LW-1:0] pack_lanes();
        logic [ROWS*LW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*LW +: LW] = m_lane[r];
        return v;
    endfunction

    task automatic model_shift();
        logic [LW-1:0] l;
        l = lfsr_used[LW-1:0];
        if (int'(l) >= LANES) l = l - LW'(LANES);
        for (int r = 0; r < ROWS - 1; r++) m_lane[r] = m_lane[r+1];
        m_lane[ROWS-1] = l;
        m_valid = {1'b1, m_valid[ROWS-1:1]};
        check("row_valid", 32'(bus.row_valid), 32'(m_valid));
        check("row_lane", 32'(bus.row_lane), 32'(pack_lanes()));
    endtask

    task automatic wait_event(input int budget, output int cycles, output logic h, output logic m, output logic s);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!(bus.hit_pulse | bus.miss_pulse | bus.shift_pulse) && cycles < budget);
        h = bus.hit_pulse;
        m = bus.miss_pulse;
        s = bus.shift_pulse;
        check("event_seen", 32'(h | m | s), 32'd1);
        if (s) model_shift();
    endtask

    task automatic start_game();
        bus.startn = 1'b0;
        step();
        bus.startn = 1'b1;
        for (int r = 0; r < ROWS; r++) m_lane[r] = '0;
        m_valid = '0;
        check("start_state", 32'(bus.state), 32'd1);
        check("start_valid", 32'(bus.row_valid), 32'd0);
        check("start_score", 32'(bus.score), 32'd0);
        check("start_lives", 32'(bus.lives_left), 32'(LIVES_EXP));
    endtask

    task automatic fill_rows();
        int cyc;
        logic h, m, s;
        for (int k = 0; k < ROWS; k++) begin
            wait_event(100, cyc, h, m, s);
            check("fill_gap", 32'(cyc), 32'd20);
            check("fill_shift", 32'(s), 32'd1);
            check("fill_miss", 32'(m), 32'd0);
        end
        check("rows_full", 32'(bus.row_valid), 32'h7F);
    endtask

    initial begin
        int   cyc;
        logic h, m, s;
        int   sp [8] = '{20, 16, 16, 12, 12, 8, 8, 8};

        bus.startn    = 1'b1;
        bus.key_press = '0;
        resetn        = 1'b0;
        step();
        step();
        resetn = 1'b1;

        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_score", 32'(bus.score), 32'd0);
        check("rst_valid", 32'(bus.row_valid), 32'd0);
        check("rst_over", 32'(bus.game_over), 32'd0);
        check("rst_lives", 32'(bus.lives_left), 32'(LIVES_EXP));
        check("rst_pulses", 32'({bus.hit_pulse, bus.miss_pulse, bus.shift_pulse}), 32'd0);

        // Unplayed board: the eighth tick finds row 0 still occupied
        start_game();
        fill_rows();
`ifdef TILE_ENGINE_LIVES_EN
        for (int i = 0; i < 3; i++) begin
            wait_event(100, cyc, h, m, s);
            check("tmiss_gap", 32'(cyc), 32'd20);
            check("tmiss_pulse", 32'(m), 32'd1);
            check("tmiss_lives", 32'(bus.lives_left), 32'(2 - i));
            check("tmiss_shift", 32'(s), (i < 2) ? 32'd1 : 32'd0);
            check("tmiss_state", 32'(bus.state), (i < 2) ? 32'd1 : 32'd2);
        end
`else
        wait_event(100, cyc, h, m, s);
        check("tmiss_gap", 32'(cyc), 32'd20);
        check("tmiss_pulse", 32'(m), 32'd1);
        check("tmiss_shift", 32'(s), 32'd0);
        check("tmiss_state", 32'(bus.state), 32'd2);
        check("tmiss_lives", 32'(bus.lives_left), 32'd0);
`endif
        check("over_flag", 32'(bus.game_over), 32'd1);
        check("over_frozen", 32'(bus.row_valid), 32'(m_valid));
        step();
        check("miss_1cycle", 32'(bus.miss_pulse), 32'd0);
        bus.key_press = 4'b0001;
        step();
        bus.key_press = '0;
        step();
        check("over_nokey", 32'({bus.hit_pulse, bus.miss_pulse}), 32'd0);

        // Eight hits: period 20 -> 16 -> 12 -> 8, then pinned at the floor
        start_game();
        fill_rows();
        for (int i = 0; i < 8; i++) begin
            bus.key_press = 4'(1 << m_lane[0]);
            exp_q.push_back(sp[i]);
            step();
            bus.key_press = '0;
            m_valid[0] = 1'b0;
            check("hit_pulse", 32'(bus.hit_pulse), 32'd1);
            check("hit_miss", 32'(bus.miss_pulse), 32'd0);
            check("hit_score", 32'(bus.score), 32'(i + 1));
            check("hit_row0", 32'(bus.row_valid[0]), 32'd0);
            wait_event(100, cyc, h, m, s);
            check("tick_gap", 32'(cyc + 1), 32'(exp_q.pop_front()));
            check("tick_shift", 32'(s), 32'd1);
        end

        // Correct press landing on the scroll edge
        for (int k = 0; k < 7; k++) step();
        bus.key_press = 4'(1 << m_lane[0]);
        step();
        bus.key_press = '0;
        check("same_hit", 32'(bus.hit_pulse), 32'd1);
        check("same_shift", 32'(bus.shift_pulse), 32'd1);
        check("same_miss", 32'(bus.miss_pulse), 32'd0);
        check("same_score", 32'(bus.score), 32'd9);
        m_valid[0] = 1'b0;
        model_shift();

        // Reset in the middle of a game
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("mid_state", 32'(bus.state), 32'd0);
        check("mid_score", 32'(bus.score), 32'd0);
        check("mid_valid", 32'(bus.row_valid), 32'd0);
        check("mid_lane", 32'(bus.row_lane), 32'd0);
        check("mid_over", 32'(bus.game_over), 32'd0);
        check("mid_lives", 32'(bus.lives_left), 32'(LIVES_EXP));

        // Two keys at once is never a hit
        start_game();
        fill_rows();
        bus.key_press = 4'b0110;
        step();
        bus.key_press = '0;
        check("multi_miss", 32'(bus.miss_pulse), 32'd1);
        check("multi_hit", 32'(bus.hit_pulse), 32'd0);
        check("multi_score", 32'(bus.score), 32'd0);
        check("multi_rows", 32'(bus.row_valid), 32'h7F);
        check("multi_shift", 32'(bus.shift_pulse), 32'd0);
`ifdef TILE_ENGINE_LIVES_EN
        check("multi_state", 32'(bus.state), 32'd1);
        check("multi_lives", 32'(bus.lives_left), 32'd2);
`else
        check("multi_state", 32'(bus.state), 32'd2);
        check("multi_over", 32'(bus.game_over), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
